// File: rtl/water_flow_monitor_if.sv
// Controller <-> flow monitor signal bundle.
// master = washing-machine controller side, slave = water_flow_monitor side.
// leak_detected exists only when WATER_LEAK_DETECT_EN is defined.
interface water_flow_monitor_if;
  logic       flow_reset;
  logic       flow_mode;
  logic [9:0] water_level_sensor;
  logic       water_flow_error;
  logic       monitor_active;
  logic [3:0] fail_count;
`ifdef WATER_LEAK_DETECT_EN
  logic       leak_detected;

  modport master (
    output flow_reset, flow_mode, water_level_sensor,
    input  water_flow_error, monitor_active, fail_count, leak_detected
  );
  modport slave (
    input  flow_reset, flow_mode, water_level_sensor,
    output water_flow_error, monitor_active, fail_count, leak_detected
  );
`else
  modport master (
    output flow_reset, flow_mode, water_level_sensor,
    input  water_flow_error, monitor_active, fail_count
  );
  modport slave (
    input  flow_reset, flow_mode, water_level_sensor,
    output water_flow_error, monitor_active, fail_count
  );
`endif
endinterface

// File: rtl/water_flow_monitor.sv
// Purpose: checks the water level moves in the commanded direction each SAMPLE_CYCLES window; latches an error.
// Latency: error rises FAIL_LIMIT*(SAMPLE_CYCLES+1)+1 cycles after flow_reset is first seen low (no movement); outputs registered.
// Backpressure: none; sensor sampled every cycle. Optional leak check compiled in with WATER_LEAK_DETECT_EN.
module water_flow_monitor #(
  parameter int         SAMPLE_CYCLES = 50_000,
  parameter int         MIN_DELTA     = 2,
  parameter int         FAIL_LIMIT    = 3,
  parameter logic [9:0] FULL_LEVEL    = 10'd1000
) (
  input logic                 clk,
  input logic                 reset,
  water_flow_monitor_if.slave bus
);
  localparam int CW = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, BASELINE, MONITOR, EVAL, FAULT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] window_cnt, window_cnt_nxt;
  logic [9:0]    baseline, baseline_nxt;
  logic          mode_q, mode_q_nxt;
  logic [3:0]    fail_count, fail_count_nxt, fail_inc;
  logic          flow_error, flow_error_nxt;
  logic          active, active_nxt;
  logic [10:0]   sample_ext, base_ext;
  logic          rise_seen, fall_seen, pass_fill, pass_drain, window_pass, last_window;
`ifdef WATER_LEAK_DETECT_EN
  logic          leak, leak_nxt;
`endif

  // Window evaluation terms; 11-bit sums so baseline+MIN_DELTA never wraps near full scale.
  always_comb begin
    sample_ext  = {1'b0, bus.water_level_sensor};
    base_ext    = {1'b0, baseline};
    rise_seen   = sample_ext >= base_ext + 11'(MIN_DELTA);
    fall_seen   = base_ext >= sample_ext + 11'(MIN_DELTA);
    pass_fill   = rise_seen || (bus.water_level_sensor >= FULL_LEVEL);
    pass_drain  = fall_seen || (bus.water_level_sensor == 10'd0);
    window_pass = mode_q ? pass_fill : pass_drain;
    last_window = window_cnt == CW'(SAMPLE_CYCLES - 1);
    fail_inc    = (fail_count >= 4'(FAIL_LIMIT)) ? 4'(FAIL_LIMIT) : fail_count + 4'd1;
  end

  // Next-state and next-output logic: flow_reset beats a mode change, which beats the normal sequence.
  always_comb begin
    state_nxt      = state;
    window_cnt_nxt = window_cnt;
    baseline_nxt   = baseline;
    mode_q_nxt     = mode_q;
    fail_count_nxt = fail_count;
`ifdef WATER_LEAK_DETECT_EN
    leak_nxt       = leak;
`endif
    case (state)
      IDLE: state_nxt = BASELINE;
      BASELINE: begin
        baseline_nxt   = bus.water_level_sensor;
        mode_q_nxt     = bus.flow_mode;
        window_cnt_nxt = '0;
        state_nxt      = MONITOR;
      end
      MONITOR: begin
        if (last_window) state_nxt = EVAL;
        else             window_cnt_nxt = window_cnt + CW'(1);
      end
      EVAL: begin
        baseline_nxt   = bus.water_level_sensor;
        window_cnt_nxt = '0;
        state_nxt      = MONITOR;
`ifdef WATER_LEAK_DETECT_EN
        // A falling level while filling means water is escaping: fault at once.
        if (mode_q && fall_seen) begin
          fail_count_nxt = fail_inc;
          leak_nxt       = 1'b1;
          state_nxt      = FAULT;
        end else
`endif
        if (window_pass) begin
          fail_count_nxt = 4'd0;
        end else begin
          fail_count_nxt = fail_inc;
          if (fail_inc == 4'(FAIL_LIMIT)) state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    // Controller changed direction mid-run: restart from a fresh baseline without blaming anyone.
    if ((state == MONITOR || state == EVAL) && (bus.flow_mode != mode_q)) begin
      state_nxt      = BASELINE;
      fail_count_nxt = 4'd0;
      baseline_nxt   = baseline;
      window_cnt_nxt = window_cnt;
`ifdef WATER_LEAK_DETECT_EN
      leak_nxt       = leak;
`endif
    end

    if (bus.flow_reset) begin
      state_nxt      = IDLE;
      fail_count_nxt = 4'd0;
`ifdef WATER_LEAK_DETECT_EN
      leak_nxt       = 1'b0;
`endif
    end

    flow_error_nxt = state_nxt == FAULT;
    active_nxt     = (state_nxt == BASELINE) || (state_nxt == MONITOR) || (state_nxt == EVAL);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      window_cnt <= '0;
      baseline   <= '0;
      mode_q     <= 1'b0;
      fail_count <= 4'd0;
      flow_error <= 1'b0;
      active     <= 1'b0;
`ifdef WATER_LEAK_DETECT_EN
      leak       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      window_cnt <= window_cnt_nxt;
      baseline   <= baseline_nxt;
      mode_q     <= mode_q_nxt;
      fail_count <= fail_count_nxt;
      flow_error <= flow_error_nxt;
      active     <= active_nxt;
`ifdef WATER_LEAK_DETECT_EN
      leak       <= leak_nxt;
`endif
    end
  end

  assign bus.water_flow_error = flow_error;
  assign bus.monitor_active   = active;
  assign bus.fail_count       = fail_count;
`ifdef WATER_LEAK_DETECT_EN
  assign bus.leak_detected    = leak;
`endif
endmodule

// File: tb/tb_water_flow_monitor.sv
// Bench for water_flow_monitor with SAMPLE_CYCLES=16, MIN_DELTA=2, FAIL_LIMIT=3, FULL_LEVEL=1000.
// Vector table of whole-run scenarios, hand-written corner sequences, then random traffic vs a timeline model.
module tb_water_flow_monitor;
  localparam int S = 16;
  localparam int D = 2;
  localparam int L = 3;
  localparam int FULL = 1000;
  localparam int WIN = S + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   level = 0;

  water_flow_monitor_if bus_if ();

  water_flow_monitor #(.SAMPLE_CYCLES(S), .MIN_DELTA(D), .FAIL_LIMIT(L), .FULL_LEVEL(10'd1000)) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_level(input int v);
    level = (v < 0) ? 0 : (v > 1023) ? 1023 : v;
    bus_if.water_level_sensor = 10'(level);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a monitored run: clear, release, then the BASELINE capture edge.
  task automatic start_run(input bit mode, input int lvl);
    bus_if.flow_reset = 1'b1;
    tick();
    bus_if.flow_mode = mode;
    drive_level(lvl);
    bus_if.flow_reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_windows(input int n, input int step);
    for (int w = 0; w < n; w++) begin
      drive_level(level + step);
      repeat (WIN) tick();
    end
  endtask

  typedef struct {
    bit mode; int start; int step; int windows;
    int exp_fail; bit exp_err; bit exp_leak;
  } vec_t;
  vec_t vecs [10];

  // Timeline model: e counts edges since the monitor left idle; a window is evaluated every S+1 edges after capture.
  bit m_idle, m_fault, m_leak, m_mode;
  int m_e, m_base, m_fails;

  task automatic model_edge(input bit fr, input bit fm, input int lvl);
    bit ok;
    if (fr) begin
      m_idle = 1; m_fault = 0; m_fails = 0; m_leak = 0;
    end else if (m_idle) begin
      m_idle = 0; m_e = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_e >= 1 && fm != m_mode) begin
      m_e = 0; m_fails = 0;
    end else begin
      m_e++;
      if (m_e == 1) begin
        m_base = lvl; m_mode = fm;
      end else if ((m_e - 1) % WIN == 0) begin
        ok = m_mode ? (lvl >= m_base + D || lvl >= FULL) : (m_base >= lvl + D || lvl == 0);
`ifdef WATER_LEAK_DETECT_EN
        if (m_mode && m_base >= lvl + D) begin
          m_fails = (m_fails + 1 > L) ? L : m_fails + 1;
          m_leak = 1; m_fault = 1;
        end else
`endif
        if (ok) m_fails = 0;
        else begin
          m_fails++;
          if (m_fails == L) m_fault = 1;
        end
        m_base = lvl;
      end
    end
  endtask

  initial begin
    bit early;
    bit fr;
    int drift;
    vecs[0] = '{1, 100,  3, 10, 0, 0, 0};
    vecs[1] = '{0, 500,  0,  3, 3, 1, 0};
    vecs[2] = '{1, 1023, 0,  5, 0, 0, 0};
    vecs[3] = '{0, 0,    0,  5, 0, 0, 0};
    vecs[4] = '{1, 200,  1,  2, 2, 0, 0};
    vecs[5] = '{0, 600, -2,  4, 0, 0, 0};
    vecs[6] = '{1, 300,  2,  3, 0, 0, 0};
`ifdef WATER_LEAK_DETECT_EN
    vecs[7] = '{1, 400, -5,  1, 1, 1, 1};
`else
    vecs[7] = '{1, 400, -5,  1, 1, 0, 0};
`endif
    vecs[8] = '{1, 999,  0,  3, 3, 1, 0};
    vecs[9] = '{1, 1000, 0,  3, 0, 0, 0};

    bus_if.flow_reset = 1'b1;
    bus_if.flow_mode = 1'b0;
    drive_level(0);
    #12;
    check("reset_error", bus_if.water_flow_error, 0);
    check("reset_active", bus_if.monitor_active, 0);
    check("reset_fail", bus_if.fail_count, 0);
`ifdef WATER_LEAK_DETECT_EN
    check("reset_leak", bus_if.leak_detected, 0);
`endif
    reset = 1'b0;
    tick();

    // Table-driven whole-run scenarios.
    for (int i = 0; i < 10; i++) begin
      start_run(vecs[i].mode, vecs[i].start);
      run_windows(vecs[i].windows, vecs[i].step);
      check($sformatf("vec%0d_fail", i), bus_if.fail_count, vecs[i].exp_fail);
      check($sformatf("vec%0d_error", i), bus_if.water_flow_error, vecs[i].exp_err);
      check($sformatf("vec%0d_active", i), bus_if.monitor_active, !vecs[i].exp_err);
`ifdef WATER_LEAK_DETECT_EN
      check($sformatf("vec%0d_leak", i), bus_if.leak_detected, vecs[i].exp_leak);
`endif
    end

    // Exact latency of the drain fault, then stickiness and flow_reset clearing.
    bus_if.flow_reset = 1'b1;
    tick();
    bus_if.flow_mode = 1'b0;
    drive_level(500);
    bus_if.flow_reset = 1'b0;
    tick();
    early = 0;
    for (int c = 1; c <= 51; c++) begin
      tick();
      if (bus_if.water_flow_error !== 1'b0) early = 1;
    end
    check("latency_no_early_error", early, 0);
    tick();
    check("latency_error_at_52", bus_if.water_flow_error, 1);
    check("fault_fail_count", bus_if.fail_count, L);
    bus_if.flow_mode = 1'b1;
    repeat (20) tick();
    check("fault_sticky_error", bus_if.water_flow_error, 1);
    check("fault_sticky_fail", bus_if.fail_count, L);
    bus_if.flow_reset = 1'b1;
    tick();
    check("flow_reset_clears_error", bus_if.water_flow_error, 0);
    check("flow_reset_clears_fail", bus_if.fail_count, 0);

    // Direction change after two failed drain windows restarts cleanly.
    start_run(0, 700);
    run_windows(2, 0);
    check("mode_pre_fail", bus_if.fail_count, 2);
    repeat (5) tick();
    bus_if.flow_mode = 1'b1;
    tick();
    check("mode_change_fail_clear", bus_if.fail_count, 0);
    check("mode_change_active", bus_if.monitor_active, 1);
    tick();
    run_windows(4, 3);
    check("mode_after_rise_error", bus_if.water_flow_error, 0);
    check("mode_after_rise_fail", bus_if.fail_count, 0);

    // Asynchronous reset mid-window with fail_count=2.
    start_run(0, 500);
    run_windows(2, 0);
    repeat (4) tick();
    check("pre_reset_fail", bus_if.fail_count, 2);
    #3 reset = 1'b1;
    #1;
    check("async_reset_fail", bus_if.fail_count, 0);
    check("async_reset_active", bus_if.monitor_active, 0);
    check("async_reset_error", bus_if.water_flow_error, 0);
    bus_if.flow_reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", bus_if.monitor_active, 0);

    // Random traffic against the timeline model.
    m_idle = 1; m_fault = 0; m_leak = 0; m_fails = 0; m_e = 0; m_base = 0; m_mode = 0;
    drift = 0;
    for (int c = 0; c < 4000; c++) begin
      fr = (c < 2) || ($urandom_range(0, 299) == 0);
      bus_if.flow_reset = fr;
      if ($urandom_range(0, 249) == 0) bus_if.flow_mode = ~bus_if.flow_mode;
      if ($urandom_range(0, 39) == 0) drift = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 3) == 0) drive_level(level + drift);
      if ($urandom_range(0, 499) == 0) drive_level($urandom_range(0, 1) == 1 ? 1023 : 0);
      model_edge(fr, bus_if.flow_mode, level);
      tick();
      check("rand_error", bus_if.water_flow_error, m_fault);
      check("rand_active", bus_if.monitor_active, !m_idle && !m_fault);
      check("rand_fail", bus_if.fail_count, m_fails);
`ifdef WATER_LEAK_DETECT_EN
      check("rand_leak", bus_if.leak_detected, m_leak);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
